// File: rtl/bayesian_result_collector.sv
// rtl/bayesian_result_collector.sv - result FIFO, accept tagging, run statistics and window average
module bayesian_result_collector #(
  parameter int DEPTH  = 4,
  parameter int WINDOW = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     core_done,
  input  logic [3:0]               mean_result,
  input  logic [3:0]               confidence_level,
  input  logic [3:0]               conf_threshold,
  input  logic                     clear,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [3:0]               out_mean,
  output logic [3:0]               out_conf,
  output logic                     out_accept,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               total_count,
  output logic [7:0]               accept_count,
  output logic [3:0]               win_avg,
  output logic                     win_valid,
  output logic                     overflow,
  output logic                     range_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(WINDOW);
  localparam int AW = 4 + LW;

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          done_q;
  logic [AW-1:0] win_acc;
  logic [LW-1:0] win_cnt;

  logic          capture, accept, pop, full, push;
  logic [AW-1:0] win_sum;
  logic          win_last;
  logic [8:0]    head;

  assign capture  = core_done & ~done_q;
  assign accept   = (confidence_level >= conf_threshold);
  assign full     = (fifo_count == (PW+1)'(DEPTH));
  assign pop      = out_valid & out_ready;
  // A full FIFO still takes the new result when the head leaves in the same cycle.
  assign push     = capture & (~full | pop);
  assign win_sum  = win_acc + AW'(mean_result);
  assign win_last = (win_cnt == LW'(WINDOW - 1));

  // Outputs are gated so an empty FIFO presents zeros rather than stale storage.
  assign head       = mem[rd_ptr];
  assign out_valid  = (fifo_count != '0);
  assign out_mean   = out_valid ? head[8:5] : 4'd0;
  assign out_conf   = out_valid ? head[4:1] : 4'd0;
  assign out_accept = out_valid & head[0];

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= {mean_result, confidence_level, accept};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      total_count  <= 8'd0;
      accept_count <= 8'd0;
      win_acc      <= '0;
      win_cnt      <= '0;
      win_avg      <= 4'd0;
      win_valid    <= 1'b0;
      overflow     <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      done_q    <= core_done;
      win_valid <= 1'b0;
      if (clear) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        fifo_count   <= '0;
        total_count  <= 8'd0;
        accept_count <= 8'd0;
        win_acc      <= '0;
        win_cnt      <= '0;
        win_avg      <= 4'd0;
        overflow     <= 1'b0;
        range_err    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      fifo_count <= fifo_count + 1'b1;
        else if (pop && !push) fifo_count <= fifo_count - 1'b1;

        // Statistics and window see every capture, including dropped ones.
        if (capture) begin
          if (!push) overflow <= 1'b1;
          if (mean_result > 4'd8) range_err <= 1'b1;
          if (total_count != 8'd255) total_count <= total_count + 8'd1;
          if (accept && accept_count != 8'd255) accept_count <= accept_count + 8'd1;
          if (win_last) begin
            win_avg   <= win_sum[AW-1:LW];
            win_valid <= 1'b1;
            win_acc   <= '0;
            win_cnt   <= '0;
          end else begin
            win_acc <= win_sum;
            win_cnt <= win_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bayesian_result_collector.sv
// tb/tb_bayesian_result_collector.sv - randomized and directed check of bayesian_result_collector
module tb_bayesian_result_collector;

  localparam int DEPTH  = 4;
  localparam int WINDOW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       core_done;
  logic [3:0] mean_result, confidence_level, conf_threshold;
  logic       clear, out_ready;
  logic       out_valid, out_accept, win_valid, overflow, range_err;
  logic [3:0] out_mean, out_conf, win_avg;
  logic [2:0] fifo_count;
  logic [7:0] total_count, accept_count;

  bayesian_result_collector #(.DEPTH(DEPTH), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .core_done(core_done), .mean_result(mean_result),
    .confidence_level(confidence_level), .conf_threshold(conf_threshold),
    .clear(clear), .out_ready(out_ready), .out_valid(out_valid), .out_mean(out_mean),
    .out_conf(out_conf), .out_accept(out_accept), .fifo_count(fifo_count),
    .total_count(total_count), .accept_count(accept_count), .win_avg(win_avg),
    .win_valid(win_valid), .overflow(overflow), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mean;
    int conf;
    int acc;
  } entry_t;

  entry_t mq[$];
  int     wq[$];
  int     m_done_q, m_total, m_accept, m_win_avg, m_win_valid, m_overflow, m_range_err;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    wq.delete();
    m_done_q = 0; m_total = 0; m_accept = 0;
    m_win_avg = 0; m_win_valid = 0; m_overflow = 0; m_range_err = 0;
  endtask

  // Next state of the model for one rising edge, from the inputs currently driven.
  task automatic model_step();
    int cap, popped, full, pushed, sum;
    cap = (core_done && !m_done_q) ? 1 : 0;
    m_done_q = core_done;
    m_win_valid = 0;
    if (clear) begin
      model_reset();
      m_done_q = core_done;
      return;
    end
    full   = (mq.size() == DEPTH);
    popped = (mq.size() > 0 && out_ready) ? 1 : 0;
    if (popped) void'(mq.pop_front());
    pushed = cap && (!full || popped);
    if (pushed) mq.push_back('{mean: int'(mean_result), conf: int'(confidence_level),
                               acc: (confidence_level >= conf_threshold) ? 1 : 0});
    if (cap) begin
      if (!pushed) m_overflow = 1;
      if (mean_result > 8) m_range_err = 1;
      if (m_total < 255) m_total++;
      if (confidence_level >= conf_threshold && m_accept < 255) m_accept++;
      wq.push_back(int'(mean_result));
      if (wq.size() == WINDOW) begin
        sum = 0;
        foreach (wq[i]) sum += wq[i];
        m_win_avg = sum / WINDOW;
        m_win_valid = 1;
        wq.delete();
      end
    end
  endtask

  task automatic compare_all();
    int v;
    v = (mq.size() > 0) ? 1 : 0;
    chk("out_valid", 32'(out_valid), v);
    chk("out_mean", 32'(out_mean), v ? mq[0].mean : 0);
    chk("out_conf", 32'(out_conf), v ? mq[0].conf : 0);
    chk("out_accept", 32'(out_accept), v ? mq[0].acc : 0);
    chk("fifo_count", 32'(fifo_count), mq.size());
    chk("total_count", 32'(total_count), m_total);
    chk("accept_count", 32'(accept_count), m_accept);
    chk("win_avg", 32'(win_avg), m_win_avg);
    chk("win_valid", 32'(win_valid), m_win_valid);
    chk("overflow", 32'(overflow), m_overflow);
    chk("range_err", 32'(range_err), m_range_err);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge after checking.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse(input int mean, input int conf, input int thr);
    core_done = 1'b1;
    mean_result = 4'(mean); confidence_level = 4'(conf); conf_threshold = 4'(thr);
    tick();
    core_done = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_mean"}, 32'(out_mean), 0);
    chk({tag, "_count"}, 32'(fifo_count), 0);
    chk({tag, "_total"}, 32'(total_count), 0);
    chk({tag, "_accept"}, 32'(accept_count), 0);
    chk({tag, "_avg"}, 32'(win_avg), 0);
    chk({tag, "_flags"}, 32'({win_valid, overflow, range_err, out_accept}), 0);
    chk({tag, "_conf"}, 32'(out_conf), 0);
  endtask

  initial begin
    rst_n = 1'b0; core_done = 1'b0; clear = 1'b0; out_ready = 1'b0;
    mean_result = '0; confidence_level = '0; conf_threshold = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Held done produces one capture
    core_done = 1'b1; mean_result = 4'd5; confidence_level = 4'd12; conf_threshold = 4'd10;
    repeat (5) tick();
    chk("hold_count", 32'(fifo_count), 1);
    chk("hold_mean", 32'(out_mean), 5);
    chk("hold_conf", 32'(out_conf), 12);
    chk("hold_accept", 32'(out_accept), 1);
    chk("hold_total", 32'(total_count), 1);
    chk("hold_acccnt", 32'(accept_count), 1);
    core_done = 1'b0; clear = 1'b1; tick(); clear = 1'b0;

    // Overflow: five results into a four-entry FIFO
    for (int i = 1; i <= 5; i++) pulse(i, 3, 9);
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_total", 32'(total_count), 5);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(out_mean), i);
      tick();
    end
    chk("drain_empty", 32'(out_valid), 0);
    out_ready = 1'b0; clear = 1'b1; tick(); clear = 1'b0;

    // Full FIFO with simultaneous capture and pop
    for (int i = 1; i <= 4; i++) pulse(i, 1, 0);
    core_done = 1'b1; mean_result = 4'd7; out_ready = 1'b1;
    tick();
    core_done = 1'b0; out_ready = 1'b0;
    chk("pp_count", 32'(fifo_count), 4);
    chk("pp_ovf", 32'(overflow), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", 32'(out_mean), (i == 3) ? 7 : i + 2);
      tick();
    end
    out_ready = 1'b0; clear = 1'b1; tick(); clear = 1'b0;

    // Window average of 8,7,6,5
    out_ready = 1'b1;
    pulse(8, 0, 0); pulse(7, 0, 0); pulse(6, 0, 0);
    core_done = 1'b1; mean_result = 4'd5; tick();
    chk("win_avg", 32'(win_avg), 6);
    chk("win_pulse", 32'(win_valid), 1);
    core_done = 1'b0; tick();
    chk("win_pulse_end", 32'(win_valid), 0);
    out_ready = 1'b0;

    // Range error, then clear colliding with a capture
    pulse(9, 4, 2);
    chk("rng_flag", 32'(range_err), 1);
    chk("rng_stored", 32'(out_mean), 9);
    core_done = 1'b1; clear = 1'b1; mean_result = 4'd3; tick();
    clear = 1'b0; core_done = 1'b0;
    chk("clr_total", 32'(total_count), 0);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_rng", 32'(range_err), 0);
    tick();

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) pulse(i + 2, 9, 4);
    chk("pre_rst_count", 32'(fifo_count), 3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    pulse(6, 2, 1);
    chk("post_rst_count", 32'(fifo_count), 1);
    chk("post_rst_mean", 32'(out_mean), 6);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      core_done        = ($urandom_range(0, 2) == 0);
      mean_result      = 4'($urandom_range(0, 9));
      confidence_level = 4'($urandom_range(0, 15));
      conf_threshold   = 4'($urandom_range(0, 15));
      out_ready        = ($urandom_range(0, 2) != 0);
      clear            = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
